// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC-8 generator and its frame serializer.
// Holds the FSM state encoding, the CRC width/seed and the tail length.
package crc_pkg;

  localparam int                CRC_WD   = 8;
  localparam logic [CRC_WD-1:0] SEED     = 8'hD8;
  localparam int                TAIL_CYC = CRC_WD + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    TAIL  = 2'd3
  } state_t;

endpackage

// File: rtl/crc_frame_serializer_piso_shifter.sv
// Parallel-in serial-out register: load wins over shift, shifts right with
// zero fill, bit 0 is the next serial bit.
module piso_shifter #(
  parameter int WD = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_shift,
  input  logic [WD-1:0] i_din,
  output logic          o_bit0
);

  logic [WD-1:0] r_shift;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
    end else if (i_load) begin
      r_shift <= i_din;
    end else if (i_shift) begin
      r_shift <= {1'b0, r_shift[WD-1:1]};
    end
  end

  assign o_bit0 = r_shift[0];

endmodule

// File: rtl/crc_frame_serializer.sv
// Frames valid/ready input words and serializes them LSB-first into the serial
// CRC generator, reseeding it before each frame and waiting out its CRC tail.
module crc_frame_serializer
  import crc_pkg::*;
#(
  parameter int DATA_WD = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DATA_WD-1:0] In_Data,
  input  logic               In_Valid,
  input  logic               In_Last,
  output logic               In_Ready,
  output logic               Ser_Data,
  output logic               Ser_Active,
  output logic               Crc_Rst_N,
  output logic               Busy,
  output logic               Frame_Done,
  output logic               Underrun
);

  // Generator needs DATA_WD valid CRC cycles plus one terminating cycle.
  localparam int                TAIL_CYCLES = DATA_WD + 1;
  localparam int                CNT_WD      = $clog2(TAIL_CYCLES + 1);
  localparam logic [CNT_WD-1:0] BIT_LAST    = CNT_WD'(DATA_WD - 1);
  localparam logic [CNT_WD-1:0] TAIL_LAST   = CNT_WD'(TAIL_CYCLES - 1);

  state_t              r_state, w_state_next;
  logic [CNT_WD-1:0]   r_bit_cnt, w_bit_cnt_next;
  logic [CNT_WD-1:0]   r_tail_cnt, w_tail_cnt_next;
  logic                r_last, w_last_next;
  logic                r_ser_data, r_ser_active, r_crc_rst_n;
  logic                r_busy, r_frame_done, r_underrun;
  logic                w_ser_data_next, w_ser_active_next, w_crc_rst_n_next;
  logic                w_busy_next, w_frame_done_next, w_underrun_next;
  logic                w_bit_end, w_accept;
  logic                w_load, w_shift, w_emit;
  logic [DATA_WD-1:0]  w_load_word;
  logic                w_shift_bit0;

  assign w_bit_end = (r_state == SHIFT) && (r_bit_cnt == BIT_LAST);
  assign In_Ready  = (r_state == IDLE) || (w_bit_end && !r_last);
  assign w_accept  = In_Valid && In_Ready;

  piso_shifter #(.WD(DATA_WD)) u_piso (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_din   (w_load_word),
    .o_bit0  (w_shift_bit0)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_tail_cnt   <= '0;
      r_last       <= 1'b0;
      r_ser_data   <= 1'b0;
      r_ser_active <= 1'b0;
      r_crc_rst_n  <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_tail_cnt   <= w_tail_cnt_next;
      r_last       <= w_last_next;
      r_ser_data   <= w_ser_data_next;
      r_ser_active <= w_ser_active_next;
      r_crc_rst_n  <= w_crc_rst_n_next;
      r_busy       <= w_busy_next;
      r_frame_done <= w_frame_done_next;
      r_underrun   <= w_underrun_next;
    end
  end

  // w_emit is the bit that goes on the wire in the next cycle; the shifter
  // always holds the bits still to be sent, so a reload mid-frame pre-shifts.
  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt;
    w_tail_cnt_next = r_tail_cnt;
    w_last_next     = r_last;
    w_load          = 1'b0;
    w_shift         = 1'b0;
    w_load_word     = In_Data;
    w_emit          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load       = 1'b1;
          w_last_next  = In_Last;
          w_state_next = CLR;
        end
      end
      CLR: begin
        w_emit         = w_shift_bit0;
        w_shift        = 1'b1;
        w_bit_cnt_next = '0;
        w_state_next   = SHIFT;
      end
      SHIFT: begin
        if (!w_bit_end) begin
          w_emit         = w_shift_bit0;
          w_shift        = 1'b1;
          w_bit_cnt_next = r_bit_cnt + 1'b1;
        end else if (w_accept) begin
          w_load         = 1'b1;
          w_load_word    = {1'b0, In_Data[DATA_WD-1:1]};
          w_emit         = In_Data[0];
          w_last_next    = In_Last;
          w_bit_cnt_next = '0;
        end else begin
          w_tail_cnt_next = '0;
          w_state_next    = TAIL;
        end
      end
      TAIL: begin
        if (r_tail_cnt == TAIL_LAST) begin
          w_tail_cnt_next = '0;
          w_state_next    = IDLE;
        end else begin
          w_tail_cnt_next = r_tail_cnt + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so they line up with it;
  // Underrun therefore shows in the first TAIL cycle after the missed word.
  always_comb begin
    w_ser_active_next = (w_state_next == SHIFT);
    w_ser_data_next   = (w_state_next == SHIFT) && w_emit;
    w_crc_rst_n_next  = (w_state_next != CLR);
    w_busy_next       = (w_state_next != IDLE);
    w_frame_done_next = (w_state_next == TAIL) && (w_tail_cnt_next == TAIL_LAST);
    w_underrun_next   = w_bit_end && !w_accept && !r_last;
  end

  assign Ser_Data   = r_ser_data;
  assign Ser_Active = r_ser_active;
  assign Crc_Rst_N  = r_crc_rst_n;
  assign Busy       = r_busy;
  assign Frame_Done = r_frame_done;
  assign Underrun   = r_underrun;

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Directed bench for crc_frame_serializer: records per-cycle output traces
// after each accept and compares them with hand-computed bit masks.
module tb_crc_frame_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       ser_data, ser_active, crc_rst_n, busy, frame_done, underrun;

  int n_checks = 0;
  int n_errors = 0;

  // bit c of each trace = value in cycle c after the accept edge
  logic [31:0] tr_rst_low, tr_active, tr_data, tr_ready, tr_done, tr_under, tr_busy;

  always #5 clk = ~clk;

  crc_frame_serializer #(.DATA_WD(8)) dut (
    .CLK        (clk),
    .RST        (rst),
    .In_Data    (in_data),
    .In_Valid   (in_valid),
    .In_Last    (in_last),
    .In_Ready   (in_ready),
    .Ser_Data   (ser_data),
    .Ser_Active (ser_active),
    .Crc_Rst_N  (crc_rst_n),
    .Busy       (busy),
    .Frame_Done (frame_done),
    .Underrun   (underrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs n cycles; drops In_Valid after any accept; raises a new word at cycle raise_c.
  task automatic observe(input int n, input int raise_c, input logic [7:0] rdata, input logic rlast);
    logic pend;
    tr_rst_low = '0; tr_active = '0; tr_data = '0; tr_ready = '0;
    tr_done = '0; tr_under = '0; tr_busy = '0;
    pend = in_valid && in_ready;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (pend) in_valid = 1'b0;
      if (c == raise_c) begin
        in_data  = rdata;
        in_last  = rlast;
        in_valid = 1'b1;
      end
      tr_rst_low[c] = !crc_rst_n;
      tr_active[c]  = ser_active;
      tr_data[c]    = ser_data;
      tr_ready[c]   = in_ready;
      tr_done[c]    = frame_done;
      tr_under[c]   = underrun;
      tr_busy[c]    = busy;
      pend = in_valid && in_ready;
    end
  endtask

  task automatic check_trace(input string tag,
                             input logic [31:0] e_rst, input logic [31:0] e_act,
                             input logic [31:0] e_dat, input logic [31:0] e_rdy,
                             input logic [31:0] e_done, input logic [31:0] e_und,
                             input logic [31:0] e_busy);
    check({tag, "_crc_rst_low"}, tr_rst_low, e_rst);
    check({tag, "_active"},      tr_active,  e_act);
    check({tag, "_data"},        tr_data,    e_dat);
    check({tag, "_ready"},       tr_ready,   e_rdy);
    check({tag, "_done"},        tr_done,    e_done);
    check({tag, "_underrun"},    tr_under,   e_und);
    check({tag, "_busy"},        tr_busy,    e_busy);
    $display("frame %s: active=%h data=%h done=%h under=%h", tag, tr_active, tr_data, tr_done, tr_under);
  endtask

  task automatic start_word(input logic [7:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ser_data",   {31'd0, ser_data},   32'd0);
    check("rst_ser_active", {31'd0, ser_active}, 32'd0);
    check("rst_crc_rst_n",  {31'd0, crc_rst_n},  32'd1);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_done",       {31'd0, frame_done}, 32'd0);
    check("rst_underrun",   {31'd0, underrun},   32'd0);
    check("rst_in_ready",   {31'd0, in_ready},   32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single word 0xA5: CLR c1, bits c2..9, TAIL c10..18, IDLE c19
    start_word(8'hA5, 1'b1);
    observe(19, 0, 8'h00, 1'b0);
    check_trace("single_a5", 32'h2, 32'h3FC, 32'h294, 32'h80000, 32'h40000, 32'h0, 32'h7FFFE);

    // 0x01 then 0x80 (last) back to back
    start_word(8'h01, 1'b0);
    observe(27, 1, 8'h80, 1'b1);
    check_trace("two_word", 32'h2, 32'h3FFFC, 32'h20004, 32'h8000200, 32'h4000000, 32'h0, 32'h7FFFFFE);

    // 0x3C non-last, no follow-up word
    start_word(8'h3C, 1'b0);
    observe(19, 0, 8'h00, 1'b0);
    check_trace("underrun", 32'h2, 32'h3FC, 32'hF0, 32'h80200, 32'h40000, 32'h400, 32'h7FFFE);

    // 0xFF offered from CLR onward; taken only in IDLE at c19
    start_word(8'h12, 1'b1);
    observe(28, 1, 8'hFF, 1'b1);
    check_trace("backpressure", 32'h100002, 32'h1FE003FC, 32'h1FE00048, 32'h80000, 32'h40000, 32'h0, 32'h1FF7FFFE);
    observe(10, 0, 8'h00, 1'b0);
    check_trace("bp_drain", 32'h0, 32'h0, 32'h0, 32'h400, 32'h200, 32'h0, 32'h3FE);

    // Reset during bit 3 of 0x55
    start_word(8'h55, 1'b1);
    observe(5, 0, 8'h00, 1'b0);
    check_trace("pre_reset", 32'h2, 32'h3C, 32'h14, 32'h0, 32'h0, 32'h0, 32'h3E);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_active",   {31'd0, ser_active}, 32'd0);
    check("midrst_busy",     {31'd0, busy},       32'd0);
    check("midrst_in_ready", {31'd0, in_ready},   32'd1);
    check("midrst_crc_rst_n",{31'd0, crc_rst_n},  32'd1);
    check("midrst_done",     {31'd0, frame_done}, 32'd0);
    observe(20, 0, 8'h00, 1'b0);
    check_trace("post_reset_idle", 32'h0, 32'h0, 32'h0, 32'h1FFFFE, 32'h0, 32'h0, 32'h0);

    start_word(8'hA5, 1'b1);
    observe(19, 0, 8'h00, 1'b0);
    check_trace("repeat_a5", 32'h2, 32'h3FC, 32'h294, 32'h80000, 32'h40000, 32'h0, 32'h7FFFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
